// File: rtl/ksa_param.sv
// RC4 key-scheduling engine driving an external single-port S RAM with one-cycle read latency.
// Optional in-engine S[i]=i fill, configurable S depth and a runtime-selectable key length.
module ksa_param #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned KEY_BYTES = 3,
   parameter int unsigned INIT_EN   = 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               en,
   output logic                               rdy,
   input  logic [8*KEY_BYTES-1:0]             key,
   input  logic [$clog2(KEY_BYTES+1)-1:0]     key_len,
   output logic [ADDR_W-1:0]                  addr,
   input  logic [ADDR_W-1:0]                  rddata,
   output logic [ADDR_W-1:0]                  wrdata,
   output logic                               wren
);

   localparam int unsigned KLEN_W = $clog2(KEY_BYTES + 1);
   localparam int unsigned KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [KLEN_W-1:0] KeyBytesL = KLEN_W'(KEY_BYTES);

   localparam logic [3:0] StIdle  = 4'd0;
   localparam logic [3:0] StInit  = 4'd1;
   localparam logic [3:0] StRdI   = 4'd2;
   localparam logic [3:0] StWaitI = 4'd3;
   localparam logic [3:0] StRdJ   = 4'd4;
   localparam logic [3:0] StWaitJ = 4'd5;
   localparam logic [3:0] StWrI   = 4'd6;
   localparam logic [3:0] StWrJ   = 4'd7;
   localparam logic [3:0] StDone  = 4'd8;

   logic [3:0]             state_q, state_d;
   logic [ADDR_W-1:0]      i_q, i_d;
   logic [ADDR_W-1:0]      j_q, j_d;
   logic [ADDR_W-1:0]      si_q, si_d;
   logic [ADDR_W-1:0]      sj_q, sj_d;
   logic [KIDX_W-1:0]      kidx_q, kidx_d;
   logic [KIDX_W-1:0]      klast_q, klast_d;
   logic [8*KEY_BYTES-1:0] key_q, key_d;

   logic [KLEN_W-1:0]      klen_eff;
   logic [ADDR_W-1:0]      kterm;
   logic [ADDR_W-1:0]      j_new;

   // Zero or oversized key_len falls back to the full key.
   always_comb begin
      klen_eff = key_len;
      if (key_len == '0 || key_len > KeyBytesL) klen_eff = KeyBytesL;
   end

   // Byte 0 is the most significant key byte; the cast truncates or zero-extends to ADDR_W.
   always_comb begin
      kterm = '0;
      for (int k = 0; k < KEY_BYTES; k++) begin
         if (kidx_q == KIDX_W'(k)) kterm = ADDR_W'(key_q[(KEY_BYTES-1-k)*8 +: 8]);
      end
   end

   assign j_new = j_q + si_q + kterm;

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      si_d    = si_q;
      sj_d    = sj_q;
      kidx_d  = kidx_q;
      klast_d = klast_q;
      key_d   = key_q;
      case (state_q)
         StIdle: begin
            if (en) begin
               key_d   = key;
               klast_d = KIDX_W'(klen_eff - KLEN_W'(1));
               i_d     = '0;
               j_d     = '0;
               kidx_d  = '0;
               state_d = (INIT_EN != 0) ? StInit : StRdI;
            end
         end
         StInit: begin
            // i wraps back to 0 on the last fill write, ready for the KSA loop.
            i_d = i_q + ADDR_W'(1);
            if (i_q == '1) state_d = StRdI;
         end
         StRdI:   state_d = StWaitI;
         StWaitI: begin
            si_d    = rddata;
            state_d = StRdJ;
         end
         StRdJ: begin
            j_d     = j_new;
            state_d = StWaitJ;
         end
         StWaitJ: begin
            sj_d    = rddata;
            state_d = StWrI;
         end
         StWrI:   state_d = StWrJ;
         StWrJ: begin
            i_d     = i_q + ADDR_W'(1);
            kidx_d  = (kidx_q == klast_q) ? '0 : kidx_q + KIDX_W'(1);
            state_d = (i_q == '1) ? StDone : StRdI;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs are a function of registered state only; RD_J uses the registered si.
   always_comb begin
      addr   = '0;
      wrdata = '0;
      wren   = 1'b0;
      rdy    = 1'b0;
      case (state_q)
         StIdle:  rdy = 1'b1;
         StInit: begin
            addr   = i_q;
            wrdata = i_q;
            wren   = 1'b1;
         end
         StRdI:   addr = i_q;
         StWaitI: addr = i_q;
         StRdJ:   addr = j_new;
         StWaitJ: addr = j_q;
         StWrI: begin
            addr   = i_q;
            wrdata = sj_q;
            wren   = 1'b1;
         end
         StWrJ: begin
            addr   = j_q;
            wrdata = si_q;
            wren   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         i_q     <= '0;
         j_q     <= '0;
         si_q    <= '0;
         sj_q    <= '0;
         kidx_q  <= '0;
         klast_q <= '0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         kidx_q  <= kidx_d;
         klast_q <= klast_d;
         key_q   <= key_d;
      end
   end

   // A start is one-shot: the engine is busy on the cycle after acceptance.
   assert property (@(posedge clk) disable iff (!rst_n) (en && rdy) |=> !rdy);
   assert property (@(posedge clk) disable iff (!rst_n) wren |-> !rdy);

endmodule

// File: tb/tb_ksa_param.sv
// Scoreboarded bench for ksa_param: three instances (N=256 with fill, N=4, N=256 without fill),
// each with its own S RAM model; a monitor per instance checks every completed run.
module tb_ksa_param;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // u0: ADDR_W=8, KEY_BYTES=3, INIT_EN=1
   logic        en0 = 1'b0, rdy0, wren0;
   logic [23:0] key0 = '0;
   logic [1:0]  klen0 = '0;
   logic [7:0]  addr0, rd0, wrdata0;
   // u1: ADDR_W=2, KEY_BYTES=1, INIT_EN=1
   logic        en1 = 1'b0, rdy1, wren1;
   logic [7:0]  key1 = '0;
   logic [0:0]  klen1 = '0;
   logic [1:0]  addr1, rd1, wrdata1;
   // u2: ADDR_W=8, KEY_BYTES=3, INIT_EN=0
   logic        en2 = 1'b0, rdy2, wren2;
   logic [23:0] key2 = '0;
   logic [1:0]  klen2 = '0;
   logic [7:0]  addr2, rd2, wrdata2;
   logic        preload2 = 1'b0;

   ksa_param #(.ADDR_W(8), .KEY_BYTES(3), .INIT_EN(1)) u0 (
      .clk(clk), .rst_n(rst_n), .en(en0), .rdy(rdy0), .key(key0), .key_len(klen0),
      .addr(addr0), .rddata(rd0), .wrdata(wrdata0), .wren(wren0));
   ksa_param #(.ADDR_W(2), .KEY_BYTES(1), .INIT_EN(1)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en1), .rdy(rdy1), .key(key1), .key_len(klen1),
      .addr(addr1), .rddata(rd1), .wrdata(wrdata1), .wren(wren1));
   ksa_param #(.ADDR_W(8), .KEY_BYTES(3), .INIT_EN(0)) u2 (
      .clk(clk), .rst_n(rst_n), .en(en2), .rdy(rdy2), .key(key2), .key_len(klen2),
      .addr(addr2), .rddata(rd2), .wrdata(wrdata2), .wren(wren2));

   logic [7:0] mem0 [256];
   logic [1:0] mem1 [4];
   logic [7:0] mem2 [256];

   always @(posedge clk) begin
      if (wren0) mem0[addr0] <= wrdata0;
      rd0 <= mem0[addr0];
      if (wren1) mem1[addr1] <= wrdata1;
      rd1 <= mem1[addr1];
      if (preload2) begin
         for (int k = 0; k < 256; k++) mem2[k] <= 8'(k);
      end else if (wren2) begin
         mem2[addr2] <= wrdata2;
      end
      rd2 <= mem2[addr2];
   end

   int ncmp  = 0;
   int nfail = 0;

   int           q_cyc  [3][$];
   bit           q_chk  [3][$];
   logic [2047:0] q_s   [3][$];
   int           q_hn   [3][$];
   logic [15:0]  q_hand [3][$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic chk_mem(input string nm, input logic [2047:0] act, input logic [2047:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         for (int k = 0; k < 256; k++) begin
            if (act[k*8 +: 8] !== exp[k*8 +: 8]) begin
               $display("FAIL %s: S[%0d] = %02h, required %02h", nm, k, act[k*8 +: 8],
                        exp[k*8 +: 8]);
               break;
            end
         end
      end
   endtask

   function automatic logic rdy_of(input int w);
      return (w == 0) ? rdy0 : (w == 1) ? rdy1 : rdy2;
   endfunction

   function automatic logic [2047:0] mem_of(input int w);
      logic [2047:0] r = '0;
      for (int k = 0; k < 256; k++) begin
         if (w == 0) r[k*8 +: 8] = mem0[k];
         else if (w == 2) r[k*8 +: 8] = mem2[k];
         else if (k < 4) r[k*8 +: 8] = {6'b0, mem1[k]};
      end
      return r;
   endfunction

   // Textbook RC4 KSA; key byte for step i is byte (i mod len), byte 0 in key[23:16].
   function automatic logic [2047:0] rc4_ref(input int n, input logic [23:0] k, input int len);
      int s [256];
      int j = 0;
      int t;
      logic [2047:0] r = '0;
      for (int i = 0; i < n; i++) s[i] = i;
      for (int i = 0; i < n; i++) begin
         j    = (j + s[i] + int'(k[(2 - (i % len))*8 +: 8])) % n;
         t    = s[i];
         s[i] = s[j];
         s[j] = t;
      end
      for (int i = 0; i < n; i++) r[i*8 +: 8] = 8'(s[i]);
      return r;
   endfunction

   task automatic expect_run(input int w, input int cyc, input bit cm, input logic [2047:0] s,
                             input int hn);
      q_cyc[w].push_back(cyc);
      q_chk[w].push_back(cm);
      q_s[w].push_back(s);
      q_hn[w].push_back(hn);
   endtask

   task automatic monitor(input int w);
      int cnt = 0;
      int ec;
      int hn;
      bit cm;
      logic [2047:0] es, act;
      logic [15:0] h;
      forever begin
         @(negedge clk);
         if (rdy_of(w) !== 1'b1) begin
            cnt++;
         end else if (cnt != 0) begin
            if (q_cyc[w].size() == 0) begin
               ncmp++;
               nfail++;
               $display("FAIL u%0d_unexpected_run: %0d busy cycles, required no run", w, cnt);
            end else begin
               ec = q_cyc[w].pop_front();
               cm = q_chk[w].pop_front();
               es = q_s[w].pop_front();
               hn = q_hn[w].pop_front();
               chk($sformatf("u%0d_busy_cycles", w), 32'(cnt), 32'(ec));
               if (cm) begin
                  act = mem_of(w);
                  chk_mem($sformatf("u%0d_final_s", w), act, es);
                  for (int k = 0; k < hn; k++) begin
                     h = q_hand[w].pop_front();
                     chk($sformatf("u%0d_s%0d", w, h[15:8]), 32'(act[int'(h[15:8])*8 +: 8]),
                         32'(h[7:0]));
                  end
               end
            end
            cnt = 0;
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);
   initial monitor(2);

   task automatic wait_rdy(input int w, input int maxc);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rdy_of(w) !== 1'b1 && n < maxc);
      chk($sformatf("u%0d_run_completes", w), 32'(rdy_of(w)), 32'd1);
   endtask

   // The key is scrambled after acceptance so the run must use the latched copy.
   task automatic start0(input logic [23:0] k, input logic [1:0] l);
      @(negedge clk);
      key0  = k;
      klen0 = l;
      en0   = 1'b1;
      @(posedge clk);
      #1;
      en0  = 1'b0;
      key0 = ~k;
   endtask

   initial begin
      logic [2047:0] m1, m2a, m;
      repeat (3) @(negedge clk);
      chk("reset_rdy0", 32'(rdy0), 32'd1);
      chk("reset_rdy1", 32'(rdy1), 32'd1);
      chk("reset_rdy2", 32'(rdy2), 32'd1);
      chk("reset_wren0", 32'(wren0), 32'd0);
      chk("reset_addr0", 32'(addr0), 32'd0);
      chk("reset_wrdata0", 32'(wrdata0), 32'd0);
      rst_n = 1'b1;

      m1 = rc4_ref(256, 24'h00033C, 3);
      expect_run(0, 1793, 1'b1, m1, 3);
      q_hand[0].push_back({8'd10, 8'hF4});
      q_hand[0].push_back({8'd20, 8'h4F});
      q_hand[0].push_back({8'd40, 8'h03});
      start0(24'h00033C, 2'd3);
      wait_rdy(0, 4000);

      m = '0;
      m[31:0] = 32'h01030200;
      expect_run(1, 29, 1'b1, m, 0);
      @(negedge clk);
      key1  = 8'h00;
      klen1 = 1'b1;
      en1   = 1'b1;
      @(posedge clk);
      #1 en1 = 1'b0;
      wait_rdy(1, 100);

      @(negedge clk);
      preload2 = 1'b1;
      @(posedge clk);
      #1 preload2 = 1'b0;
      expect_run(2, 1537, 1'b1, m1, 0);
      @(negedge clk);
      key2  = 24'h00033C;
      klen2 = 2'd3;
      en2   = 1'b1;
      @(posedge clk);
      #1 en2 = 1'b0;
      wait_rdy(2, 3000);

      expect_run(0, 1793, 1'b1, rc4_ref(256, 24'h2A0000, 1), 0);
      start0(24'h2A0000, 2'd1);
      wait_rdy(0, 4000);
      m2a = rc4_ref(256, 24'h2A0000, 3);
      expect_run(0, 1793, 1'b1, m2a, 0);
      start0(24'h2A0000, 2'd0);
      wait_rdy(0, 4000);
      expect_run(0, 1793, 1'b1, m2a, 0);
      start0(24'h2A0000, 2'd3);
      wait_rdy(0, 4000);

      // en held high (with a mid-run toggle): one run, then an immediate restart.
      expect_run(0, 1793, 1'b1, m1, 0);
      expect_run(0, 1793, 1'b1, m1, 0);
      @(negedge clk);
      key0  = 24'h00033C;
      klen0 = 2'd3;
      en0   = 1'b1;
      repeat (300) @(negedge clk);
      en0 = 1'b0;
      @(negedge clk);
      en0 = 1'b1;
      wait_rdy(0, 4000);
      @(posedge clk);
      #1 chk("restart_after_idle", 32'(rdy0), 32'd0);
      en0 = 1'b0;
      wait_rdy(0, 4000);
      repeat (3) @(negedge clk);
      chk("no_extra_run", 32'(rdy0), 32'd1);

      // Abort at cycle 500, then a clean run.
      expect_run(0, 500, 1'b0, '0, 0);
      start0(24'h0102FF, 2'd2);
      repeat (500) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_rdy", 32'(rdy0), 32'd1);
      chk("abort_wren", 32'(wren0), 32'd0);
      chk("abort_addr", 32'(addr0), 32'd0);
      #2 rst_n = 1'b1;
      expect_run(0, 1793, 1'b1, rc4_ref(256, 24'h0102FF, 2), 0);
      start0(24'h0102FF, 2'd2);
      wait_rdy(0, 4000);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(q_cyc[0].size() + q_cyc[1].size() + q_cyc[2].size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
